// File: rtl/id_issue_queue.sv
// id_issue_queue: in-order decode/issue queue with per-register pending-write scoreboard
module id_issue_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_inst,
  input  logic [31:0]            in_pc,
  output logic                   out_valid,
  input  logic                   EX_allow_in,
  output logic [31:0]            out_inst,
  output logic [31:0]            out_pc,
  output logic [4:0]             out_raddr1,
  output logic [4:0]             out_raddr2,
  output logic [4:0]             out_dest,
  output logic                   out_rf_we,
  input  logic                   wb_we,
  input  logic [4:0]             wb_waddr,
  input  logic                   br_flush,
  input  logic                   ex_flush,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] inst_q [DEPTH];
  logic [31:0] pc_q [DEPTH];
  logic [AW:0] wp, rp;
  logic [CNT_W-1:0] cnt [32];
  logic [CNT_W-1:0] eff [32];
  logic [31:0] wb_hit, wb_dec;
  logic [4:0] rd, rj, rk;
  logic [5:0] op6;
  logic is_b, is_bl, is_jirl, is_bcc, is_st, is_ld, is_imm, is_lu, is_pca;
  logic is_csr, is_crd, is_cwr, is_cxc, is_sys, is_ertn;
  logic uses_rj, src2_rd, src2_none, empty, full, hazard, fire, issue_w, enq;

  assign count    = wp - rp;
  assign empty    = count == '0;
  assign full     = count == (AW+1)'(DEPTH);
  assign in_ready = !full;
  assign out_inst = inst_q[rp[AW-1:0]];
  assign out_pc   = pc_q[rp[AW-1:0]];

  assign rd  = out_inst[4:0];
  assign rj  = out_inst[9:5];
  assign rk  = out_inst[14:10];
  assign op6 = out_inst[31:26];
  assign is_b    = op6 == 6'h14;
  assign is_bl   = op6 == 6'h15;
  assign is_jirl = op6 == 6'h13;
  assign is_bcc  = op6 >= 6'h16 && op6 <= 6'h1b;
  assign is_st   = out_inst[31:24] == 8'h29;
  assign is_ld   = out_inst[31:24] == 8'h28 || out_inst[31:24] == 8'h2a;
  assign is_imm  = out_inst[31:25] == 7'h01 || out_inst[31:20] == 12'h004;
  assign is_lu   = out_inst[31:25] == 7'h0a;
  assign is_pca  = out_inst[31:25] == 7'h0e;
  assign is_csr  = out_inst[31:24] == 8'h04;
  assign is_crd  = is_csr && rj == 5'd0;
  assign is_cwr  = is_csr && rj == 5'd1;
  assign is_cxc  = is_csr && rj > 5'd1;
  assign is_sys  = out_inst[31:15] == 17'h00056;
  assign is_ertn = out_inst == 32'h06483800;

  assign uses_rj   = !(is_b || is_bl || is_lu || is_pca || is_crd || is_cwr || is_sys || is_ertn);
  assign src2_rd   = is_st || is_bcc || is_cwr || is_cxc;
  assign src2_none = is_imm || is_ld || is_jirl || is_b || is_bl || is_lu || is_pca || is_crd || is_sys || is_ertn;
  assign out_raddr1 = uses_rj ? rj : 5'd0;
  assign out_raddr2 = src2_rd ? rd : src2_none ? 5'd0 : rk;
  assign out_rf_we  = !(is_st || is_bcc || is_b || is_sys || is_ertn);
  assign out_dest   = is_bl ? 5'd1 : rd;

  // a retiring WB frees its register in the same cycle, so dependents see the post-WB count
  always_comb begin
    for (int r = 0; r < 32; r++) begin
      wb_hit[r] = wb_we && wb_waddr == 5'(r) && r != 0;
      wb_dec[r] = wb_hit[r] && cnt[r] != '0;
      eff[r]    = cnt[r] - CNT_W'(wb_dec[r]);
    end
  end

  assign hazard    = eff[out_raddr1] != '0 || eff[out_raddr2] != '0 || (out_rf_we && eff[out_dest] == '1);
  assign out_valid = !empty && !hazard && !br_flush && !ex_flush;
  assign fire      = out_valid && EX_allow_in;
  assign issue_w   = fire && out_rf_we;
  assign enq       = in_valid && in_ready && !br_flush && !ex_flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      for (int r = 0; r < 32; r++) cnt[r] <= '0;
    end else begin
      wp <= wp + (AW+1)'(enq);
      rp <= (br_flush || ex_flush) ? wp : rp + (AW+1)'(fire);
      for (int r = 0; r < 32; r++)
        cnt[r] <= ex_flush ? '0 :
                  (issue_w && out_dest == 5'(r) && r != 0 && !wb_hit[r]) ? cnt[r] + 1'b1 :
                  (wb_dec[r] && !(issue_w && out_dest == 5'(r))) ? cnt[r] - 1'b1 : cnt[r];
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      inst_q[wp[AW-1:0]] <= in_inst;
      pc_q[wp[AW-1:0]]   <= in_pc;
    end
  end
endmodule

// File: tb/tb_id_issue_queue.sv
// tb_id_issue_queue: directed and random checks of id_issue_queue against a queue/scoreboard model
module tb_id_issue_queue;
  localparam int DEPTH = 4;
  localparam int CNT_W = 2;
  localparam int CMAX = 3;
  localparam logic [31:0] BASE [18] = '{32'h00100000, 32'h00110000, 32'h02800000, 32'h28800000,
    32'h29800000, 32'h58000000, 32'h50000000, 32'h54000000, 32'h4c000000, 32'h14000000,
    32'h1c000000, 32'h04000000, 32'h04000000, 32'h04000000, 32'h002b0000, 32'h06483800,
    32'h00408000, 32'h68000000};

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [4:0]  r1, r2, dest;
    logic        we;
  } ent_t;

  logic clk = 0, reset, in_valid, in_ready, out_valid, EX_allow_in, out_rf_we;
  logic wb_we, br_flush, ex_flush;
  logic [31:0] in_inst, in_pc, out_inst, out_pc;
  logic [4:0] out_raddr1, out_raddr2, out_dest, wb_waddr;
  logic [2:0] count;

  ent_t q[$];
  int mc [32];
  ent_t nxt;
  logic [31:0] pcg;
  bit used;
  int vectors = 0, miscompares = 0;

  id_issue_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .out_valid(out_valid), .EX_allow_in(EX_allow_in), .out_inst(out_inst),
    .out_pc(out_pc), .out_raddr1(out_raddr1), .out_raddr2(out_raddr2), .out_dest(out_dest),
    .out_rf_we(out_rf_we), .wb_we(wb_we), .wb_waddr(wb_waddr), .br_flush(br_flush),
    .ex_flush(ex_flush), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic ent_t mk(input int k, input logic [4:0] d, input logic [4:0] j,
                              input logic [4:0] kk, input logic [31:0] pc);
    ent_t e;
    if (k == 11) j = 5'd0;
    if (k == 12) j = 5'd1;
    if (k == 13 && j < 5'd2) j = j + 5'd2;
    e.pc   = pc;
    e.inst = (k == 14 || k == 15) ? BASE[k] : BASE[k] | {17'd0, kk, j, d};
    e.r1   = (k inside {0, 1, 2, 3, 4, 5, 8, 13, 16, 17}) ? j : 5'd0;
    e.r2   = (k inside {0, 1}) ? kk : (k inside {4, 5, 12, 13, 17}) ? d : 5'd0;
    e.we   = !(k inside {4, 5, 6, 14, 15, 17});
    e.dest = (k == 7) ? 5'd1 : e.inst[4:0];
    return e;
  endfunction

  function automatic int eff(input int r);
    if (wb_we && wb_waddr == 5'(r) && mc[r] > 0) return mc[r] - 1;
    return mc[r];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic put(input int k, input logic [4:0] d, input logic [4:0] j, input logic [4:0] kk);
    nxt = mk(k, d, j, kk, pcg);
    pcg = pcg + 4;
  endtask

  task automatic step();
    ent_t h;
    bit ne, hz, ev, fire, enq;
    int d, w;
    #1;
    ne = q.size() > 0;
    hz = 0;
    if (ne) begin
      h = q[0];
      hz = (h.r1 != 0 && eff(h.r1) > 0) || (h.r2 != 0 && eff(h.r2) > 0) ||
           (h.we && h.dest != 0 && eff(h.dest) == CMAX);
    end
    ev = ne && !hz && !br_flush && !ex_flush;
    vectors++;
    chk("count", 32'(count), 32'(q.size()));
    chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    chk("out_valid", 32'(out_valid), 32'(ev));
    if (ne) begin
      chk("out_inst", out_inst, h.inst);
      chk("out_pc", out_pc, h.pc);
      chk("out_raddr1", 32'(out_raddr1), 32'(h.r1));
      chk("out_raddr2", 32'(out_raddr2), 32'(h.r2));
      chk("out_dest", 32'(out_dest), 32'(h.dest));
      chk("out_rf_we", 32'(out_rf_we), 32'(h.we));
    end
    fire = ev && EX_allow_in;
    enq = in_valid && q.size() < DEPTH && !br_flush && !ex_flush;
    if (ex_flush) begin
      q.delete();
      foreach (mc[i]) mc[i] = 0;
    end else begin
      d = (fire && h.we) ? int'(h.dest) : 0;
      w = wb_we ? int'(wb_waddr) : 0;
      if (d != w) begin
        if (d != 0) mc[d]++;
        if (w != 0 && mc[w] > 0) mc[w]--;
      end
      if (br_flush) q.delete();
      else begin
        if (fire) void'(q.pop_front());
        if (enq) q.push_back(nxt);
      end
    end
    used = enq;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic go(input bit iv, input bit ea, input bit we, input logic [4:0] wa,
                    input bit bf, input bit ef);
    in_valid = iv; EX_allow_in = ea; wb_we = we; wb_waddr = wa;
    br_flush = bf; ex_flush = ef; in_inst = nxt.inst; in_pc = nxt.pc;
    step();
  endtask

  initial begin
    reset = 1; in_valid = 0; EX_allow_in = 0; wb_we = 0; wb_waddr = 0;
    br_flush = 0; ex_flush = 0; pcg = 32'h1c000000;
    foreach (mc[i]) mc[i] = 0;
    put(0, 1, 0, 0);
    in_inst = nxt.inst; in_pc = nxt.pc;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_count", 32'(count), 0);
    chk("reset_in_ready", 32'(in_ready), 1);
    chk("reset_out_valid", 32'(out_valid), 0);
    reset = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin put(0, 5'(10 + i), 0, 0); go(1, 0, 0, 0, 0, 0); end
    chk("fill_count", 32'(count), 4);
    chk("fill_in_ready", 32'(in_ready), 0);
    put(0, 20, 0, 0); go(1, 0, 0, 0, 0, 0);
    repeat (4) go(0, 1, 0, 0, 0, 0);
    chk("drain_count", 32'(count), 0);
    for (int i = 0; i < 4; i++) go(0, 0, 1, 5'(10 + i), 0, 0);
    put(0, 5, 1, 2); go(1, 0, 0, 0, 0, 0);
    put(2, 6, 5, 0); go(1, 1, 0, 0, 0, 0);
    go(0, 1, 0, 0, 0, 0);
    go(0, 1, 0, 0, 0, 0);
    chk("raw_stall", 32'(out_valid), 0);
    go(0, 1, 1, 5, 0, 0);
    go(0, 0, 1, 6, 0, 0);
    put(4, 7, 3, 0); go(1, 0, 0, 0, 0, 0);
    go(0, 1, 0, 0, 0, 0);
    put(0, 0, 1, 2); go(1, 0, 0, 0, 0, 0);
    put(0, 9, 0, 0); go(1, 1, 0, 0, 0, 0);
    go(0, 1, 0, 0, 0, 0);
    go(0, 0, 1, 9, 0, 0);
    for (int i = 0; i < 4; i++) begin put(0, 4, 0, 0); go(1, 0, 0, 0, 0, 0); end
    repeat (3) go(0, 1, 0, 0, 0, 0);
    go(0, 1, 0, 0, 0, 0);
    chk("sat_stall", 32'(out_valid), 0);
    go(0, 1, 1, 4, 0, 0);
    repeat (3) go(0, 0, 1, 4, 0, 0);
    put(0, 4, 0, 0); go(1, 0, 0, 0, 0, 0);
    go(0, 1, 0, 0, 0, 0);
    put(0, 4, 0, 0); go(1, 0, 0, 0, 0, 0);
    put(2, 9, 4, 0); go(1, 0, 0, 0, 0, 0);
    put(0, 11, 0, 0); go(1, 0, 0, 0, 0, 0);
    put(0, 12, 0, 0); go(1, 0, 0, 0, 0, 0);
    put(0, 13, 0, 0); go(1, 1, 1, 4, 0, 0);
    chk("full_fire_count", 32'(count), 3);
    go(0, 1, 0, 0, 0, 0);
    go(0, 1, 1, 4, 0, 0);
    repeat (2) go(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin put(2, 5'(13 + i), 9, 0); go(1, 0, 0, 0, 0, 0); end
    put(0, 14, 0, 0); go(1, 0, 0, 0, 1, 0);
    chk("br_flush_count", 32'(count), 0);
    put(2, 15, 9, 0); go(1, 0, 0, 0, 0, 0);
    go(0, 1, 0, 0, 0, 0);
    chk("br_keep_stall", 32'(out_valid), 0);
    go(0, 1, 0, 0, 0, 1);
    chk("ex_flush_count", 32'(count), 0);
    put(2, 15, 9, 0); go(1, 0, 0, 0, 0, 0);
    go(0, 1, 0, 0, 0, 0);
    go(0, 0, 1, 15, 0, 0);
    put(0, 3, 1, 2); go(1, 0, 0, 0, 0, 0);
    go(1, 0, 0, 0, 0, 0);
    reset = 1;
    #1;
    chk("midreset_count", 32'(count), 0);
    chk("midreset_in_ready", 32'(in_ready), 1);
    chk("midreset_out_valid", 32'(out_valid), 0);
    q.delete();
    foreach (mc[i]) mc[i] = 0;
    @(negedge clk);
    reset = 0;
    used = 1;
    for (int n = 0; n < 800; n++) begin
      if (used) put($urandom_range(0, 17), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)));
      go($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
         5'($urandom_range(0, 7)), $urandom_range(0, 31) == 0, $urandom_range(0, 63) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
